// File: rtl/id_gb8_put_8x8_block.sv
// Decoder-side band writer: scatters 8x8 RGB block words (6 words x 8 rows) into
// raster positions of the band buffer, then stalls until the reader releases the band.
module id_gb8_put_8x8_block #(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 32,
  parameter int WORDS_PER_ROW = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [15:0]       IC_X_image,
  input  logic [15:0]       IC_X_image_x3,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              buffer_wr_en,
  output logic [ADDR_W-1:0] buffer_address,
  output logic [DATA_W-1:0] buffer_wr_data,
  output logic              block_done,
  output logic              band_full,
  input  logic              band_release
);

  localparam int CV_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CV_W-1:0]   count_value;
  logic [2:0]        count_row;
  logic [9:0]        count_block;
  logic [ADDR_W-1:0] first_addr, row_addr;
  logic [9:0]        max_blk;
  logic [ADDR_W-1:0] stride;
  logic              clr, xfer, row_end, blk_end, last_blk;

  // Only the block count and word stride fields of the geometry inputs are used.
  logic unused_geom;
  assign unused_geom = ^{IC_X_image[15:13], IC_X_image[2:0],
                         IC_X_image_x3[15], IC_X_image_x3[1:0]};

  assign max_blk  = IC_X_image[12:3];
  assign stride   = ADDR_W'(IC_X_image_x3[14:2]);
  assign clr      = !reset_n || !enable;
  assign in_ready = (state == WRITE);
  assign xfer     = in_valid && in_ready;
  assign row_end  = (count_value == CV_W'(WORDS_PER_ROW - 1));
  assign blk_end  = row_end && (count_row == 3'd7);
  assign last_blk = (count_block == max_blk - 10'd1);

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (max_blk != 10'd0)             state_nxt = WRITE;
      WRITE:      if (xfer && blk_end && last_blk)  state_nxt = WAIT_DRAIN;
      WAIT_DRAIN: if (band_release)                 state_nxt = WRITE;
      default:                                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_value    <= '0;
      count_row      <= '0;
      count_block    <= '0;
      first_addr     <= '0;
      row_addr       <= '0;
      buffer_wr_en   <= 1'b0;
      buffer_address <= '0;
      buffer_wr_data <= '0;
      block_done     <= 1'b0;
      band_full      <= 1'b0;
    end else begin
      buffer_wr_en <= xfer;
      block_done   <= xfer && blk_end;
      if (state == WAIT_DRAIN && band_release) band_full <= 1'b0;
      if (xfer) begin
        buffer_address <= row_addr + ADDR_W'(count_value);
        buffer_wr_data <= in_data;
        if (!row_end) begin
          count_value <= count_value + 1'b1;
        end else begin
          count_value <= '0;
          if (!blk_end) begin
            count_row <= count_row + 3'd1;
            row_addr  <= row_addr + stride;
          end else begin
            count_row <= '0;
            // Last block of the band wraps back to the band origin.
            if (last_blk) begin
              first_addr  <= '0;
              row_addr    <= '0;
              count_block <= '0;
              band_full   <= 1'b1;
            end else begin
              first_addr  <= first_addr + ADDR_W'(WORDS_PER_ROW);
              row_addr    <= first_addr + ADDR_W'(WORDS_PER_ROW);
              count_block <= count_block + 10'd1;
            end
          end
        end
      end
    end
  end

endmodule
